serial_pattern_tx: RTL and testbench

Serial bit-stream transmitter, the driving end of the serial sequence-detector path. It accepts a parallel word of up to WIDTH bits through a valid/ready load handshake and shifts it out one bit per clock on ser_out, with framing flags ser_valid and ser_last. It replaces the hand-written clock/bit stimulus: it feeds the detector FSMs in simulation and the serial input of the detector on hardware.

---
 rtl/serial_pattern_tx.sv | 123 ++++++++++++
 tb/tb_serial_pattern_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Purpose: parallel-load serial transmitter; shifts a word of up to WIDTH bits out on ser_out.
// Latency: first bit on ser_out one cycle after the load accept edge; done one cycle after the last bit.
// Backpressure: tx_en=0 freezes the shifter; load_ready is high in IDLE or on the final bit with tx_en=1.
module serial_pattern_tx #(
  parameter int WIDTH     = 11,
  parameter int LEN_W     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic             tx_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [WIDTH-1:0] masked, ld_vec;
  logic [LEN_W-1:0] cnt, cnt_nx;
  logic [LEN_W-1:0] len_eff;
  logic             done_r, done_nx;
  logic             zpend, zpend_nx;
  logic             last_bit, eow, accept;

  // Clamp the length, drop unused data bits and align so the next bit is always at a fixed end.
  always_comb begin
    len_eff = (int'(load_len) > WIDTH) ? LEN_W'(WIDTH) : load_len;
    for (int i = 0; i < WIDTH; i++) begin
      masked[i] = load_data[i] & (i < int'(len_eff));
    end
    if (MSB_FIRST) begin
      ld_vec = masked << (WIDTH - int'(len_eff));
    end else begin
      ld_vec = masked;
    end
  end

  // Handshake and serial outputs are decoded from the current state, count and tx_en.
  always_comb begin
    last_bit   = (state == SHIFT) && (cnt == LEN_W'(1));
    eow        = last_bit && tx_en;
    load_ready = (state == IDLE) || eow;
    accept     = load_valid && load_ready;
    ser_valid  = (state == SHIFT) && tx_en;
    ser_last   = last_bit;
    done       = done_r;
    if (state == SHIFT) begin
      ser_out = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    end else begin
      ser_out = 1'b0;
    end
  end

  // Next-state logic; a zero-length word taken at the end-of-word edge queues a second done pulse.
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    done_nx  = zpend;
    zpend_nx = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (len_eff != '0) begin
            state_nx = SHIFT;
            shreg_nx = ld_vec;
            cnt_nx   = len_eff;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (tx_en) begin
          shreg_nx = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          cnt_nx   = cnt - LEN_W'(1);
          if (last_bit) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
            shreg_nx = '0;
            cnt_nx   = '0;
            if (accept) begin
              if (len_eff != '0) begin
                state_nx = SHIFT;
                shreg_nx = ld_vec;
                cnt_nx   = len_eff;
              end else begin
                zpend_nx = 1'b1;
              end
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset abandons any word in flight and suppresses its done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
      zpend  <= 1'b0;
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      cnt    <= cnt_nx;
      done_r <= done_nx;
      zpend  <= zpend_nx;
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Purpose: directed self-checking bench for serial_pattern_tx (MSB-first and LSB-first instances).
// Latency: inputs driven 1ns after each rising edge, outputs sampled on the falling edge.
// Backpressure: tx_en stalls are scripted per cycle; every wait is a fixed cycle count.
module tb_serial_pattern_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [10:0] load_data;
  logic [3:0]  load_len;
  logic        tx_en;

  logic load_ready, ser_out, ser_valid, ser_last, done;
  logic l_load_ready, l_ser_out, l_ser_valid, l_ser_last, l_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(11), .LEN_W(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_len(load_len), .tx_en(tx_en),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_last(ser_last), .done(done)
  );

  serial_pattern_tx #(.WIDTH(11), .LEN_W(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(l_load_ready),
    .load_data(load_data), .load_len(load_len), .tx_en(tx_en),
    .ser_out(l_ser_out), .ser_valid(l_ser_valid), .ser_last(l_ser_last), .done(l_done)
  );

  task automatic check(input string tag, input int cyc, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Checks all five outputs of the MSB-first instance.
  task automatic chk5(input string tag, input int cyc, input logic so, input logic sv,
                      input logic sl, input logic dn, input logic rd);
    check({tag, ".ser_out"},    cyc, ser_out,    so);
    check({tag, ".ser_valid"},  cyc, ser_valid,  sv);
    check({tag, ".ser_last"},   cyc, ser_last,   sl);
    check({tag, ".done"},       cyc, done,       dn);
    check({tag, ".load_ready"}, cyc, load_ready, rd);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [10:0] w;
    logic [4:0]  e;
    logic [10:0] d;
    bit st_tx [9];
    bit st_out[9];
    bit st_vld[9];

    rst = 1'b1; load_valid = 1'b0; load_data = '0; load_len = '0; tx_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk5("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset.l_ready", 0, l_load_ready, 1'b1);
    check("reset.l_done",  0, l_done,       1'b0);

    // Full-width MSB-first word.
    nxt();
    w = 11'b01011101100;
    load_valid = 1'b1; load_data = w; load_len = 4'd11;
    @(negedge clk);
    check("w1.accept_ready", 0, load_ready, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      nxt();
      load_valid = 1'b0;
      @(negedge clk);
      if (k <= 11) chk5("w1", k, w[11-k], 1'b1, k == 11, 1'b0, k == 11);
      else         chk5("w1", k, 1'b0, 1'b0, 1'b0, k == 12, 1'b1);
    end

    // Back-to-back words with load_valid held high.
    nxt();
    e = 5'b10101;
    load_valid = 1'b1; load_data = 11'b101; load_len = 4'd3;
    for (int k = 1; k <= 6; k++) begin
      nxt();
      if (k == 1) begin load_data = 11'b01; load_len = 4'd2; end
      if (k >= 4) load_valid = 1'b0;
      @(negedge clk);
      if (k <= 5) chk5("b2b", k, e[5-k], 1'b1, (k == 3) || (k == 5), k == 4, (k == 3) || (k == 5));
      else        chk5("b2b", k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end

    // LSB-first short word.
    nxt();
    d = 11'h005;
    load_valid = 1'b1; load_data = d; load_len = 4'd3;
    for (int k = 1; k <= 4; k++) begin
      nxt();
      load_valid = 1'b0;
      @(negedge clk);
      if (k <= 3) begin
        check("lsb.ser_out",  k, l_ser_out,  d[k-1]);
        check("lsb.ser_last", k, l_ser_last, k == 3);
      end else begin
        check("lsb.done", k, l_done, 1'b1);
      end
    end

    // Length 15 clamps to 11 on both instances.
    nxt();
    d = 11'b10110011101;
    load_valid = 1'b1; load_data = d; load_len = 4'd15;
    for (int k = 1; k <= 12; k++) begin
      nxt();
      load_valid = 1'b0;
      @(negedge clk);
      if (k <= 11) begin
        check("clamp.l_ser_out",  k, l_ser_out,  d[k-1]);
        check("clamp.l_ser_last", k, l_ser_last, k == 11);
        check("clamp.ser_out",    k, ser_out,    d[11-k]);
      end else begin
        check("clamp.l_done",      k, l_done,      1'b1);
        check("clamp.done",        k, done,        1'b1);
        check("clamp.l_ser_valid", k, l_ser_valid, 1'b0);
      end
    end

    // Stall for three cycles on the second bit of 10110.
    nxt();
    st_tx  = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
    st_out = '{1, 0, 0, 0, 0, 1, 1, 0, 0};
    st_vld = '{1, 0, 0, 0, 1, 1, 1, 1, 0};
    load_valid = 1'b1; load_data = 11'b10110; load_len = 4'd5;
    for (int k = 1; k <= 9; k++) begin
      nxt();
      load_valid = 1'b0;
      tx_en = st_tx[k-1];
      @(negedge clk);
      chk5("stall", k, st_out[k-1], st_vld[k-1], k == 8, k == 9, (k == 8) || (k == 9));
    end
    tx_en = 1'b1;

    // Zero-length word.
    nxt();
    load_valid = 1'b1; load_data = 11'h7ff; load_len = 4'd0;
    @(negedge clk);
    check("zero.ready0", 0, load_ready, 1'b1);
    for (int k = 1; k <= 2; k++) begin
      nxt();
      load_valid = 1'b0;
      @(negedge clk);
      chk5("zero", k, 1'b0, 1'b0, 1'b0, k == 1, 1'b1);
    end

    // Reset on the fifth bit of 11001010, then a fresh word.
    nxt();
    w = 11'b11001010;
    load_valid = 1'b1; load_data = w; load_len = 4'd8;
    for (int k = 1; k <= 5; k++) begin
      nxt();
      load_valid = 1'b0;
      @(negedge clk);
      check("mid.ser_out", k, ser_out, w[8-k]);
    end
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk5("mid_rst", 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nxt();
    w = 11'b0110;
    load_valid = 1'b1; load_data = w; load_len = 4'd4;
    @(negedge clk);
    chk5("mid_rst", 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      nxt();
      load_valid = 1'b0;
      @(negedge clk);
      if (k <= 4) chk5("after_rst", k, w[4-k], 1'b1, k == 4, 1'b0, k == 4);
      else        chk5("after_rst", k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
